main_fsm: RTL

Multicycle main controller of the MCU. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the select inputs of the datapath's 2:1 and 4:1 multiplexers (iord, alusrca, regdst, memtoreg, alusrcb, pcsrc) and all register/memory write strobes. It sits directly upstream of those muxes and beside the ALU decoder, which consumes its aluop.

---
 rtl/main_fsm_pkg.sv | 65 ++++++
 rtl/main_outdec.sv | 62 ++++++
 rtl/main_fsm.sv | 84 ++++++++
 3 files changed

// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// mux-select encodings and the decoded control word.
package main_fsm_pkg;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_JUMP      = 2'b10;

   // Raw per-state control word; mem_gated marks states whose strobes
   // only fire once the memory reports completion.
   typedef struct packed {
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       pcwrite;
      logic       branch;
      logic       mem_gated;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      logic legal;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
         default:                                      legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/main_outdec.sv
// Pure combinational decode from controller state to the raw control word.
module main_outdec
   import main_fsm_pkg::*;
(
   input  logic [3:0] state,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alusrcb   = SRCB_FOUR;
            ctrl.irwrite   = 1'b1;
            ctrl.pcwrite   = 1'b1;
            ctrl.mem_gated = 1'b1;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMM_SH2;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.iord = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.memwrite  = 1'b1;
            ctrl.mem_gated = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.regwrite = 1'b1;
         end
         S_JEX: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main controller: state register, next-state logic, and the
// mem_ready / reset gating applied on top of the per-state decode.
module main_fsm
   import main_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic       illegal_op,
   output logic [3:0] state
);

   logic [3:0] state_q;
   logic [3:0] state_d;
   ctrl_t      ctrl;
   logic       strobe_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   main_outdec u_outdec (
      .state (state_q),
      .ctrl  (ctrl)
   );

   // mem_ready means the access issued by the current state completes this
   // cycle; states waiting on it hold and suppress their strobes until then.
   assign strobe_ok = reset_n & (~ctrl.mem_gated | mem_ready);

   assign iord     = ctrl.iord;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign pcsrc    = ctrl.pcsrc;
   assign aluop    = ctrl.aluop;

   assign irwrite    = ctrl.irwrite  & strobe_ok;
   assign memwrite   = ctrl.memwrite & strobe_ok;
   assign regwrite   = ctrl.regwrite & strobe_ok;
   assign pcen       = ((ctrl.pcwrite & strobe_ok) | (ctrl.branch & zero)) & reset_n;
   assign illegal_op = reset_n & (state_q == S_DECODE) & ~is_legal_op(op);

   assign state = state_q;

endmodule
